// File: rtl/crypt_stream_port.sv
// rtl/crypt_stream_port.sv - byte-serial stream front/back end for the 16-byte crypt core.
// Collects a block, waits the core latency, captures the selected result bank and drains it byte by byte.
module crypt_stream_port #(
   parameter int NBYTES   = 16,
   parameter int KEY_W    = 10,
   parameter int CORE_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode_i,
   input  logic [KEY_W-1:0]      key_i,
   input  logic [7:0]            s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [NBYTES*8-1:0]   blk_o,
   output logic                  mode_o,
   output logic [KEY_W-1:0]      key_o,
   input  logic [NBYTES*8-1:0]   res_enc_i,
   input  logic [NBYTES*8-1:0]   res_dec_i,
   output logic [7:0]            m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic                  busy_o
);

   localparam int BW    = NBYTES * 8;
   localparam int CNT_W = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT);

   typedef enum logic [1:0] {S_FILL, S_WAIT, S_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]      blk_q, blk_d;
   logic [BW-1:0]      res_q, res_d;
   logic               mode_q, mode_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [7:0]         m_data_q, m_data_d;
   logic               m_valid_q, m_valid_d;
   logic               in_acc, out_acc, cap;

   // Byte k sits at the MSB end: bits [8k:8k+7] in [0:127] numbering.
   function automatic logic [7:0] byte_at(input logic [BW-1:0] v, input logic [3:0] k);
      return v[{~k, 3'b000} +: 8];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FILL;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (in_acc && idx_q == 4'd15) state_d = S_WAIT;
         S_WAIT:  if (cap) state_d = S_DRAIN;
         S_DRAIN: if (out_acc && idx_q == 4'd15) state_d = S_FILL;
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      s_ready_o = (state_q == S_FILL);
      busy_o    = (state_q != S_FILL);
      in_acc    = s_valid_i & s_ready_o;
      out_acc   = m_valid_q & m_ready_i;
      cap       = (state_q == S_WAIT) && (cnt_q == CNT_W'(CORE_LAT - 1));
   end

   always_comb begin
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      blk_d     = blk_q;
      res_d     = res_q;
      mode_d    = mode_q;
      key_d     = key_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      case (state_q)
         S_FILL: begin
            cnt_d = '0;
            if (in_acc) begin
               blk_d[{~idx_q, 3'b000} +: 8] = s_data_i;
               if (idx_q == 4'd0) begin
                  mode_d = mode_i;
                  key_d  = key_i;
               end
               idx_d = idx_q + 4'd1;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cap) begin
               res_d = mode_q ? res_dec_i : res_enc_i;
               cnt_d = '0;
            end
         end
         S_DRAIN: begin
            // First DRAIN cycle loads the output register from the captured result.
            if (!m_valid_q) begin
               m_valid_d = 1'b1;
               m_data_d  = byte_at(res_q, idx_q);
            end else if (out_acc) begin
               if (idx_q == 4'd15) begin
                  m_valid_d = 1'b0;
                  idx_d     = 4'd0;
               end else begin
                  idx_d    = idx_q + 4'd1;
                  m_data_d = byte_at(res_q, idx_q + 4'd1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         cnt_q     <= '0;
         blk_q     <= '0;
         res_q     <= '0;
         mode_q    <= 1'b0;
         key_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         blk_q     <= blk_d;
         res_q     <= res_d;
         mode_q    <= mode_d;
         key_q     <= key_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign blk_o     = blk_q;
   assign mode_o    = mode_q;
   assign key_o     = key_q;
   assign m_data_o  = m_data_q;
   assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_crypt_stream_port.sv
// tb/tb_crypt_stream_port.sv - directed self-checking bench for crypt_stream_port.
module tb_crypt_stream_port;

   logic         clk = 1'b0;
   logic         rst;
   logic         mode_i;
   logic [9:0]   key_i;
   logic [7:0]   s_data_i;
   logic         s_valid_i;
   logic         s_ready_o;
   logic [127:0] blk_o;
   logic         mode_o;
   logic [9:0]   key_o;
   logic [127:0] res_enc_i;
   logic [127:0] res_dec_i;
   logic [7:0]   m_data_o;
   logic         m_valid_o;
   logic         m_ready_i;
   logic         busy_o;

   int checks = 0;
   int errors = 0;
   int lat;

   localparam logic [127:0] BLK_00 = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] BLK_40 = 128'h404142434445464748494A4B4C4D4E4F;
   localparam logic [127:0] BLK_60 = 128'h606162636465666768696A6B6C6D6E6F;
   localparam logic [127:0] BLK_80 = 128'h808182838485868788898A8B8C8D8E8F;
   localparam logic [127:0] BLK_90 = 128'h909192939495969798999A9B9C9D9E9F;
   localparam logic [127:0] BLK_A0 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
   localparam logic [127:0] ENC_E0 = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;
   localparam logic [127:0] DEC_D0 = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;
   localparam logic [127:0] ENC_B0 = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;

   crypt_stream_port #(.NBYTES(16), .KEY_W(10), .CORE_LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_i    (mode_i),
      .key_i     (key_i),
      .s_data_i  (s_data_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .blk_o     (blk_o),
      .mode_o    (mode_o),
      .key_o     (key_o),
      .res_enc_i (res_enc_i),
      .res_dec_i (res_dec_i),
      .m_data_o  (m_data_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the last handshake.
   task automatic send_block(input logic [7:0] base, input logic md, input logic [9:0] ky,
                             input int n, input bit hold);
      int t;
      for (int i = 0; i < n; i++) begin
         s_valid_i = 1'b1;
         s_data_i  = base + 8'(i);
         mode_i    = (i == 0) ? md : ~md;
         key_i     = (i == 0) ? ky : ~ky;
         t = 0;
         while (!s_ready_o && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) chk("send_timeout", 128'd0, 128'd1);
         @(posedge clk);
         @(negedge clk);
      end
      if (hold) s_data_i = 8'h55;
      else      s_valid_i = 1'b0;
   endtask

   task automatic wait_first(output int cycles);
      cycles = 0;
      while (!m_valid_o && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic recv_block(input logic [127:0] exp, input int n, input bit toggle);
      int t;
      m_ready_i = 1'b1;
      for (int k = 0; k < n; k++) begin
         t = 0;
         while (!m_valid_o && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) chk("recv_timeout", 128'd0, 128'd1);
         chk($sformatf("out_byte%0d", k), {120'd0, m_data_o}, {120'd0, exp[8*(15-k) +: 8]});
         chk($sformatf("s_ready_drain%0d", k), {127'd0, s_ready_o}, 128'd0);
         if (toggle) begin
            m_ready_i = 1'b0;
            @(negedge clk);
            chk($sformatf("stall_data%0d", k), {120'd0, m_data_o}, {120'd0, exp[8*(15-k) +: 8]});
            chk($sformatf("stall_valid%0d", k), {127'd0, m_valid_o}, 128'd1);
            m_ready_i = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end
      m_ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      mode_i    = 1'b0;
      key_i     = '0;
      s_data_i  = '0;
      s_valid_i = 1'b0;
      m_ready_i = 1'b0;
      res_enc_i = ENC_E0;
      res_dec_i = DEC_D0;
      @(negedge clk);
      chk("rst_s_ready", {127'd0, s_ready_o}, 128'd1);
      chk("rst_m_valid", {127'd0, m_valid_o}, 128'd0);
      chk("rst_m_data", {120'd0, m_data_o}, 128'd0);
      chk("rst_blk", blk_o, 128'd0);
      chk("rst_mode", {127'd0, mode_o}, 128'd0);
      chk("rst_key", {118'd0, key_o}, 128'd0);
      chk("rst_busy", {127'd0, busy_o}, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: encrypt, no stalls
      send_block(8'h00, 1'b0, 10'h282, 16, 1'b0);
      chk("t1_blk", blk_o, BLK_00);
      chk("t1_mode", {127'd0, mode_o}, 128'd0);
      chk("t1_key", {118'd0, key_o}, 128'h282);
      chk("t1_busy_wait", {127'd0, busy_o}, 128'd1);
      chk("t1_s_ready_wait", {127'd0, s_ready_o}, 128'd0);
      wait_first(lat);
      chk("t1_latency", 128'(lat), 128'd3);
      recv_block(ENC_E0, 16, 1'b0);
      chk("t1_m_valid_end", {127'd0, m_valid_o}, 128'd0);
      chk("t1_s_ready_end", {127'd0, s_ready_o}, 128'd1);
      chk("t1_busy_end", {127'd0, busy_o}, 128'd0);

      // 2: decrypt bank selected
      send_block(8'h40, 1'b1, 10'h155, 16, 1'b0);
      chk("t2_blk", blk_o, BLK_40);
      chk("t2_mode", {127'd0, mode_o}, 128'd1);
      chk("t2_key", {118'd0, key_o}, 128'h155);
      wait_first(lat);
      chk("t2_latency", 128'(lat), 128'd3);
      recv_block(DEC_D0, 16, 1'b0);

      // 3: alternating backpressure
      send_block(8'h60, 1'b0, 10'h3FF, 16, 1'b0);
      chk("t3_blk", blk_o, BLK_60);
      wait_first(lat);
      chk("t3_latency", 128'(lat), 128'd3);
      recv_block(ENC_E0, 16, 1'b1);
      chk("t3_s_ready_end", {127'd0, s_ready_o}, 128'd1);

      // 4: mode/key churn and s_valid_i held through WAIT/DRAIN
      send_block(8'h80, 1'b1, 10'h0AA, 16, 1'b1);
      chk("t4_mode", {127'd0, mode_o}, 128'd1);
      chk("t4_key", {118'd0, key_o}, 128'h0AA);
      wait_first(lat);
      chk("t4_latency", 128'(lat), 128'd3);
      recv_block(DEC_D0, 16, 1'b0);
      s_valid_i = 1'b0;
      chk("t4_blk_kept", blk_o, BLK_80);
      chk("t4_mode_kept", {127'd0, mode_o}, 128'd1);
      chk("t4_key_kept", {118'd0, key_o}, 128'h0AA);
      send_block(8'h90, 1'b0, 10'h111, 16, 1'b0);
      chk("t4_next_blk", blk_o, BLK_90);
      wait_first(lat);
      recv_block(ENC_E0, 16, 1'b0);

      // 5: reset in the middle of filling
      send_block(8'h30, 1'b1, 10'h3C3, 7, 1'b0);
      rst = 1'b1;
      #1;
      chk("t5_rst_blk", blk_o, 128'd0);
      chk("t5_rst_s_ready", {127'd0, s_ready_o}, 128'd1);
      chk("t5_rst_busy", {127'd0, busy_o}, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      res_enc_i = ENC_B0;
      @(negedge clk);
      send_block(8'hA0, 1'b0, 10'h2A5, 16, 1'b0);
      chk("t5_blk", blk_o, BLK_A0);
      chk("t5_no_stale", {127'd0, m_valid_o}, 128'd0);
      wait_first(lat);
      chk("t5_latency", 128'(lat), 128'd3);
      recv_block(ENC_B0, 16, 1'b0);

      // 6: reset in the middle of draining
      send_block(8'hA0, 1'b1, 10'h07E, 16, 1'b0);
      wait_first(lat);
      recv_block(DEC_D0, 5, 1'b0);
      chk("t6_valid_before", {127'd0, m_valid_o}, 128'd1);
      chk("t6_byte5", {120'd0, m_data_o}, 128'hD5);
      rst = 1'b1;
      #1;
      chk("t6_rst_m_valid", {127'd0, m_valid_o}, 128'd0);
      chk("t6_rst_s_ready", {127'd0, s_ready_o}, 128'd1);
      chk("t6_rst_m_data", {120'd0, m_data_o}, 128'd0);
      chk("t6_rst_busy", {127'd0, busy_o}, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_block(8'h00, 1'b0, 10'h282, 16, 1'b0);
      chk("t6_blk", blk_o, BLK_00);
      chk("t6_key", {118'd0, key_o}, 128'h282);
      wait_first(lat);
      chk("t6_latency", 128'(lat), 128'd3);
      recv_block(ENC_B0, 16, 1'b0);
      chk("t6_m_valid_end", {127'd0, m_valid_o}, 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
